// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, runs each against an external ALU using a 4-entry regfile, returns results.
// Define ALU_XCHECK_EN to flag ALU outputs whose Zero/SLT flags disagree with the result.
module alu_cmd_sequencer #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_rd,
    input  logic [1:0]        cmd_rs1,
    input  logic [1:0]        cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_slt,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_slt,
    output logic              rsp_zero,
    output logic              rsp_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = DATA_W + 9;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_LOADI = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic [CW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]     head;
    logic [2:0]        h_op;
    logic [1:0]        h_rd, h_rs1, h_rs2;
    logic [DATA_W-1:0] h_imm;
    logic              push, pop, empty;
    logic [DATA_W-1:0] rf [4];
    logic [2:0]        cur_op;
    logic [1:0]        cur_rd;
    logic [DATA_W-1:0] cur_imm;
    logic              is_load, is_ill, x_err;

    assign empty     = wr_ptr == rd_ptr;
    assign cmd_ready = !(wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == IDLE && !empty;
    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign h_op      = head[CW-1 -: 3];
    assign h_rd      = head[CW-4 -: 2];
    assign h_rs1     = head[CW-6 -: 2];
    assign h_rs2     = head[CW-8 -: 2];
    assign h_imm     = head[DATA_W-1:0];
    assign is_load   = cur_op == OP_LOADI;
    assign is_ill    = cur_op == OP_ILL;

`ifdef ALU_XCHECK_EN
    assign x_err = !is_load && !is_ill &&
                   ((alu_zero != (alu_result == '0)) ||
                    (cur_op == OP_SLT ? (alu_slt != alu_result[0] || alu_result[DATA_W-1:1] != '0) : alu_slt));
`else
    assign x_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm};
    end

    // Operands are latched at pop; the previous write-back always lands first since RESP separates EXECs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cur_op     <= '0;
            cur_rd     <= '0;
            cur_imm    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_slt    <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            case (state)
                IDLE: if (pop) begin
                    cur_op     <= h_op;
                    cur_rd     <= h_rd;
                    cur_imm    <= h_imm;
                    alu_a      <= rf[h_rs1];
                    alu_b      <= rf[h_rs2];
                    alu_opcode <= h_op;
                    state      <= EXEC;
                end
                EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= is_ill ? '0 : is_load ? cur_imm : alu_result;
                    rsp_slt    <= is_ill || is_load ? 1'b0 : alu_slt;
                    rsp_zero   <= is_ill ? 1'b0 : is_load ? cur_imm == '0 : alu_zero;
                    rsp_err    <= is_ill || x_err;
                    if (!is_ill) rf[cur_rd] <= is_load ? cur_imm : alu_result;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
